// File: rtl/io_input_conditioner.sv
// Synchronises raw buttons/switches, debounces buttons (press/release pulses, SYNC_STAGES+DEBOUNCE_CYCLES edges).
// IO_SW_DEBOUNCE_EN: switches also debounced with the same FSM (no switch pulses); otherwise sync-only.
module io_input_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] i_io_btn,
  input  logic [NUM_SW-1:0]  i_io_sw,
  output logic [NUM_BTN-1:0] o_io_btn,
  output logic [NUM_SW-1:0]  o_io_sw,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] STABLE_HI = 2'd0;
  localparam logic [1:0] WAIT_LO   = 2'd1;
  localparam logic [1:0] STABLE_LO = 2'd2;
  localparam logic [1:0] WAIT_HI   = 2'd3;

  // Index 0 is the first capture flop; index SYNC_STAGES-1 is the safe output.
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_sync;
  logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_sync <= '1;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], i_io_btn};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], i_io_sw};
    end
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press;
    logic          rel;
    logic          s;

    assign s = btn_sync[SYNC_STAGES-1][b];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= STABLE_HI;
        cnt   <= '0;
        level <= 1'b1;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          STABLE_HI: begin
            if (!s) begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (s) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_LO;
              cnt   <= '0;
              level <= 1'b0;
              press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STABLE_LO: begin
            if (s) begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
            end
          end
          default: begin
            if (!s) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_HI;
              cnt   <= '0;
              level <= 1'b1;
              rel   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        endcase
      end
    end

    assign o_io_btn[b]      = level;
    assign o_btn_press[b]   = press;
    assign o_btn_release[b] = rel;
  end

`ifdef IO_SW_DEBOUNCE_EN
  // Same debounce FSM as the buttons, but idle-low and without pulses.
  for (genvar w = 0; w < NUM_SW; w++) begin : g_sw
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          s;

    assign s = sw_sync[SYNC_STAGES-1][w];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= STABLE_LO;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        case (state)
          STABLE_HI: begin
            if (!s) begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (s) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_LO;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STABLE_LO: begin
            if (s) begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
            end
          end
          default: begin
            if (!s) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_HI;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        endcase
      end
    end

    assign o_io_sw[w] = level;
  end
`else
  assign o_io_sw = sw_sync[SYNC_STAGES-1];
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed table-driven bench for io_input_conditioner at default parameters.
module tb_io_input_conditioner;

`ifdef IO_SW_DEBOUNCE_EN
  localparam int SWL = 18;
`else
  localparam int SWL = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  btn;
  logic [31:0] sw;
  logic [3:0]  o_io_btn;
  logic [31:0] o_io_sw;
  logic [3:0]  o_btn_press;
  logic [3:0]  o_btn_release;

  int checks = 0;
  int errors = 0;

  logic [3:0] acc_press = '0;
  logic [3:0] acc_rel   = '0;

  io_input_conditioner dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_io_btn      (btn),
    .i_io_sw       (sw),
    .o_io_btn      (o_io_btn),
    .o_io_sw       (o_io_sw),
    .o_btn_press   (o_btn_press),
    .o_btn_release (o_btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sticky record of any pulse seen since the last table check.
  always @(posedge clk) begin
    #1;
    acc_press = acc_press | o_btn_press;
    acc_rel   = acc_rel | o_btn_release;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [3:0]  btn;
    logic [31:0] sw;
    int          adv;
    logic [3:0]  e_btn;
    logic [31:0] e_sw;
    logic [3:0]  e_pr;
    logic [3:0]  e_rl;
    logic [3:0]  a_pr;
    logic [3:0]  a_rl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic [3:0] b, input logic [31:0] s, input int adv,
                     input logic [3:0] eb, input logic [31:0] es, input logic [3:0] epr,
                     input logic [3:0] erl, input logic [3:0] apr, input logic [3:0] arl);
    vec_t v;
    v.name = name; v.btn = b; v.sw = s; v.adv = adv;
    v.e_btn = eb; v.e_sw = es; v.e_pr = epr; v.e_rl = erl; v.a_pr = apr; v.a_rl = arl;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".btn"},   32'(o_io_btn), 32'hF);
    check({tag, ".sw"},    o_io_sw, 32'h0);
    check({tag, ".press"}, 32'(o_btn_press), 32'h0);
    check({tag, ".rel"},   32'(o_btn_release), 32'h0);
  endtask

  initial begin
    add("idle",        4'hF, 32'h0,         3,  4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("press_wait",  4'h7, 32'h0,         17, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("press_edge",  4'h7, 32'h0,         1,  4'h7, 32'h0,         4'h8, 4'h0, 4'h8, 4'h0);
    add("press_after", 4'h7, 32'h0,         1,  4'h7, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("press_hold",  4'h7, 32'h0,         21, 4'h7, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("rel_wait",    4'hF, 32'h0,         17, 4'h7, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("rel_edge",    4'hF, 32'h0,         1,  4'hF, 32'h0,         4'h0, 4'h8, 4'h0, 4'h8);
    add("rel_after",   4'hF, 32'h0,         1,  4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("glitch15",    4'hD, 32'h0,         15, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("glitch15_end",4'hF, 32'h0,         20, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("g16_low",     4'hD, 32'h0,         16, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("g16_pre",     4'hF, 32'h0,         1,  4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("g16_accept",  4'hF, 32'h0,         1,  4'hD, 32'h0,         4'h2, 4'h0, 4'h2, 4'h0);
    add("g16_relwait", 4'hF, 32'h0,         15, 4'hD, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("g16_release", 4'hF, 32'h0,         1,  4'hF, 32'h0,         4'h0, 4'h2, 4'h0, 4'h2);
    add("all_prwait",  4'h0, 32'h0,         17, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("all_press",   4'h0, 32'h0,         1,  4'h0, 32'h0,         4'hF, 4'h0, 4'hF, 4'h0);
    add("all_rlwait",  4'hF, 32'h0,         17, 4'h0, 32'h0,         4'h0, 4'h0, 4'h0, 4'h0);
    add("all_release", 4'hF, 32'h0,         1,  4'hF, 32'h0,         4'h0, 4'hF, 4'h0, 4'hF);
    add("sw_wait",     4'hF, 32'hA5A5_A5A5, SWL-1, 4'hF, 32'h0,      4'h0, 4'h0, 4'h0, 4'h0);
    add("sw_set",      4'hF, 32'hA5A5_A5A5, 1,  4'hF, 32'hA5A5_A5A5, 4'h0, 4'h0, 4'h0, 4'h0);
    add("sw_clr",      4'hF, 32'h0,         SWL, 4'hF, 32'h0,        4'h0, 4'h0, 4'h0, 4'h0);

    // Reset: outputs must be at reset values before any clock edge.
    rst_n = 1'b1;
    btn   = 4'h0;
    sw    = 32'hFFFF_FFFF;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("reset_pre_clk");
    repeat (3) tick();
    check_reset_vals("reset_clocked");
    btn   = 4'hF;
    sw    = 32'h0;
    rst_n = 1'b1;
    acc_press = '0;
    acc_rel   = '0;

    foreach (tbl[i]) begin
      btn = tbl[i].btn;
      sw  = tbl[i].sw;
      repeat (tbl[i].adv) tick();
      check({tbl[i].name, ".btn"},     32'(o_io_btn), 32'(tbl[i].e_btn));
      check({tbl[i].name, ".sw"},      o_io_sw, tbl[i].e_sw);
      check({tbl[i].name, ".press"},   32'(o_btn_press), 32'(tbl[i].e_pr));
      check({tbl[i].name, ".rel"},     32'(o_btn_release), 32'(tbl[i].e_rl));
      check({tbl[i].name, ".acc_pr"},  32'(acc_press), 32'(tbl[i].a_pr));
      check({tbl[i].name, ".acc_rl"},  32'(acc_rel), 32'(tbl[i].a_rl));
      acc_press = '0;
      acc_rel   = '0;
    end

    // Bounce on btn[0]: 3-cycle runs never reach the debounce threshold.
    for (int c = 0; c < 30; c++) begin
      btn[0] = ((c / 3) % 2) == 1;
      tick();
      check($sformatf("bounce_c%0d.btn", c), 32'(o_io_btn), 32'hF);
    end
    btn[0] = 1'b0;
    for (int c = 1; c < 18; c++) begin
      tick();
      check($sformatf("settle_e%0d.btn", c), 32'(o_io_btn), 32'hF);
    end
    check("settle.acc_pr", 32'(acc_press), 32'h0);
    tick();
    check("settle_e18.btn",   32'(o_io_btn), 32'hE);
    check("settle_e18.press", 32'(o_btn_press), 32'h1);
    check("settle_e18.acc",   32'(acc_press), 32'h1);
    tick();
    check("settle_e19.press", 32'(o_btn_press), 32'h0);

    // Reset in the middle of a btn[2] debounce count.
    btn = 4'h7;
    sw  = 32'hA5A5_A5A5;
    repeat (20) tick();
    check("premid.btn", 32'(o_io_btn), 32'h7);
    check("premid.sw",  o_io_sw, 32'hA5A5_A5A5);
    btn = 4'h3;
    repeat (10) tick();
    check("midcount.btn", 32'(o_io_btn), 32'h7);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst_now");
    for (int c = 0; c < 5; c++) begin
      tick();
      check_reset_vals($sformatf("mid_rst_c%0d", c));
    end
    rst_n = 1'b1;
    acc_press = '0;
    acc_rel   = '0;
    repeat (17) tick();
    check("post_rst_e17.btn", 32'(o_io_btn), 32'hF);
    check("post_rst_e17.acc", 32'(acc_press), 32'h0);
    tick();
    check("post_rst_e18.btn",   32'(o_io_btn), 32'h3);
    check("post_rst_e18.press", 32'(o_btn_press), 32'hC);
    check("post_rst_e18.sw",    o_io_sw, 32'hA5A5_A5A5);
    tick();
    check("post_rst_e19.press", 32'(o_btn_press), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
